// File: rtl/irrigation_zone_sequencer_if.sv
// Bundle between the decision logic and the zone sequencer: requests in, valve drives and status out.
// master = request source / valve-driver side, slave = the sequencer.
interface irrigation_zone_sequencer_if #(
    parameter int ZONES = 4
);
    localparam int ZW = $clog2(ZONES);

    logic             enable_i;
    logic [ZONES-1:0] sprinkler_req_i;
    logic [ZONES-1:0] drip_req_i;
    logic [ZONES-1:0] sprinkler_valve_o;
    logic [ZONES-1:0] drip_valve_o;
    logic [ZW-1:0]    active_zone_o;
    logic [1:0]       status_o;
    logic             busy_o;
    logic [ZONES-1:0] fault_o;

    modport master (
        output enable_i, sprinkler_req_i, drip_req_i,
        input  sprinkler_valve_o, drip_valve_o, active_zone_o, status_o, busy_o, fault_o
    );

    modport slave (
        input  enable_i, sprinkler_req_i, drip_req_i,
        output sprinkler_valve_o, drip_valve_o, active_zone_o, status_o, busy_o, fault_o
    );
endinterface

// File: rtl/irrigation_zone_sequencer.sv
// Round-robin multi-zone valve sequencer, one valve open at a time; IRRIG_DEAD_TIME_EN stretches CLOSE to DEAD_CYCLES.
// Latency: request seen in IDLE -> SELECT next edge -> valve open after the following edge; all outputs registered.
// Backpressure: none; valve drivers always accept, requests are level-sampled every cycle.
module irrigation_zone_sequencer #(
    parameter int ZONES         = 4,
    parameter int MIN_ON_CYCLES = 8,
    parameter int MAX_ON_CYCLES = 64,
    parameter int CNT_W         = 8,
    parameter int DEAD_CYCLES   = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    irrigation_zone_sequencer_if.slave  bus
);
    localparam int ZW = $clog2(ZONES);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SPR   = 2'b01;
    localparam logic [1:0] ST_DRIP  = 2'b10;
    localparam logic [1:0] ST_TRANS = 2'b11;

    if (ZONES < 2 || ZONES > 16 || MIN_ON_CYCLES < 1 || MAX_ON_CYCLES < MIN_ON_CYCLES ||
        DEAD_CYCLES < 1 || (MAX_ON_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_params
        $error("irrigation_zone_sequencer: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, SELECT, OPEN, CLOSE} state_t;

    state_t           state;
    logic [ZW-1:0]    ptr;
    logic             first_sel;
    logic [ZW-1:0]    zone_q;
    logic             mode_spr;
    logic [CNT_W-1:0] on_cnt;
    logic [ZONES-1:0] spr_valve_q;
    logic [ZONES-1:0] drip_valve_q;
    logic [1:0]       status_q;
    logic             busy_q;
    logic [ZONES-1:0] fault_q;

`ifdef IRRIG_DEAD_TIME_EN
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    logic [DW-1:0] dead_cnt;
`endif

    logic [ZONES-1:0]   spr_req;
    logic [ZONES-1:0]   drip_req;
    logic [ZONES-1:0]   eligible;
    logic [ZONES-1:0]   conflict;
    logic               enable;

    assign enable   = bus.enable_i;
    assign spr_req  = bus.sprinkler_req_i;
    assign drip_req = bus.drip_req_i;
    assign conflict = spr_req & drip_req;
    assign eligible = spr_req ^ drip_req;

    // Rotate eligibility so the scan always begins at bit 0 of elig_rot.
    logic [ZW-1:0]      scan_start;
    logic [2*ZONES-1:0] elig_rot;
    logic [ZW-1:0]      pick;
    logic               hit;

    always_comb begin
        scan_start = '0;
        if (!first_sel && ptr != ZW'(ZONES - 1)) begin
            scan_start = ptr + ZW'(1);
        end
        elig_rot = {eligible, eligible} >> scan_start;
        hit  = 1'b0;
        pick = '0;
        for (int i = 0; i < ZONES; i++) begin
            if (!hit && elig_rot[i]) begin
                hit  = 1'b1;
                pick = ZW'((int'(scan_start) + i) % ZONES);
            end
        end
    end

    logic [ZONES-1:0] pick_mask;
    logic             pick_spr;
    logic             held;
    logic             open_exit;
    logic             close_done;
    logic             restart;

    assign pick_mask = ZONES'(1) << pick;
    assign pick_spr  = spr_req[pick];
    assign held      = mode_spr ? spr_req[zone_q] : drip_req[zone_q];
    // enable drop and conflict bypass the minimum on-time
    assign open_exit = (!held && on_cnt >= CNT_W'(MIN_ON_CYCLES - 1)) ||
                       (on_cnt == CNT_W'(MAX_ON_CYCLES - 1)) ||
                       !enable || conflict[zone_q];
    assign restart   = enable && (|eligible);

`ifdef IRRIG_DEAD_TIME_EN
    assign close_done = (dead_cnt == DW'(DEAD_CYCLES - 1));
`else
    assign close_done = 1'b1;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            ptr          <= '0;
            first_sel    <= 1'b1;
            zone_q       <= '0;
            mode_spr     <= 1'b0;
            on_cnt       <= '0;
            spr_valve_q  <= '0;
            drip_valve_q <= '0;
            status_q     <= ST_IDLE;
            busy_q       <= 1'b0;
            fault_q      <= '0;
`ifdef IRRIG_DEAD_TIME_EN
            dead_cnt     <= '0;
`endif
        end else begin
            fault_q <= conflict;
            case (state)
                IDLE: begin
                    if (restart) begin
                        state    <= SELECT;
                        status_q <= ST_TRANS;
                        busy_q   <= 1'b1;
                    end
                end
                SELECT: begin
                    if (enable && hit) begin
                        state    <= OPEN;
                        zone_q   <= pick;
                        mode_spr <= pick_spr;
                        on_cnt   <= '0;
                        if (pick_spr) begin
                            spr_valve_q <= pick_mask;
                            status_q    <= ST_SPR;
                        end else begin
                            drip_valve_q <= pick_mask;
                            status_q     <= ST_DRIP;
                        end
                    end else begin
                        state    <= IDLE;
                        status_q <= ST_IDLE;
                        busy_q   <= 1'b0;
                    end
                end
                OPEN: begin
                    if (open_exit) begin
                        state        <= CLOSE;
                        spr_valve_q  <= '0;
                        drip_valve_q <= '0;
                        status_q     <= ST_TRANS;
`ifdef IRRIG_DEAD_TIME_EN
                        dead_cnt     <= '0;
`endif
                    end else begin
                        on_cnt <= on_cnt + CNT_W'(1);
                    end
                end
                CLOSE: begin
                    ptr       <= zone_q;
                    first_sel <= 1'b0;
                    if (close_done) begin
                        if (restart) begin
                            state <= SELECT;
                        end else begin
                            state    <= IDLE;
                            status_q <= ST_IDLE;
                            busy_q   <= 1'b0;
                        end
                    end
`ifdef IRRIG_DEAD_TIME_EN
                    else begin
                        dead_cnt <= dead_cnt + DW'(1);
                    end
`endif
                end
                default: begin
                    state    <= IDLE;
                    status_q <= ST_IDLE;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sprinkler_valve_o = spr_valve_q;
    assign bus.drip_valve_o      = drip_valve_q;
    assign bus.active_zone_o     = zone_q;
    assign bus.status_o          = status_q;
    assign bus.busy_o            = busy_q;
    assign bus.fault_o           = fault_q;
endmodule
